// File: rtl/cellrv32_xirq_prio.sv
// External interrupt controller with per-channel priority, runtime trigger config and claim/complete.
// Optional THRESH register at 0x14 is enabled by defining CELLRV32_XIRQ_PRIO_THRESHOLD_EN.
module cellrv32_xirq_prio #(
  parameter int          XIRQ_NUM_CH           = 32,
  parameter logic [31:0] XIRQ_TRIGGER_TYPE     = '0,
  parameter logic [31:0] XIRQ_TRIGGER_POLARITY = '0,
  parameter int          PRIO_BITS             = 3,
  parameter int          SYNC_STAGES           = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic [31:0] xirq_i,
  output logic        cpu_irq_o
);

  localparam logic [31:0] xirq_base_c = 32'hFFFF_FF80;
  localparam int          xirq_size_c = 64;
  localparam int          ADDR_LSB    = $clog2(xirq_size_c);
  localparam logic [31:0] CH_MASK     = 32'((64'd1 << XIRQ_NUM_CH) - 64'd1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state;
  logic [4:0]           src;
  logic [31:0]          eie, eip, ttype, tpol;
  logic [PRIO_BITS-1:0] prio [32];
  logic [31:0]          sync_q [SYNC_STAGES];
  logic [31:0]          s, d_q, trig, clr, cand, elig;
  logic                 acc_en, wr_en, esc_wr, complete;
  logic [3:0]           reg_sel;
  logic [31:0]          rdata;
  logic                 win_found;
  logic [4:0]           win_ch;
  logic [PRIO_BITS-1:0] win_prio;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  assign acc_en   = (addr_i[31:ADDR_LSB] == xirq_base_c[31:ADDR_LSB]);
  assign reg_sel  = addr_i[5:2];
  assign wr_en    = wren_i & acc_en;
  assign esc_wr   = wr_en && (reg_sel == 4'h2);
  assign complete = esc_wr && (state == BUSY);

`ifdef CELLRV32_XIRQ_PRIO_THRESHOLD_EN
  logic [PRIO_BITS-1:0] thresh;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      thresh <= '0;
    end else if (wr_en && (reg_sel == 4'h5)) begin
      thresh <= data_i[PRIO_BITS-1:0];
    end
  end

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      elig[i] = (prio[i] >= thresh);
    end
  end
`else
  assign elig = '1;
`endif

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      d_q <= '0;
    end else begin
      sync_q[0] <= xirq_i & CH_MASK;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      d_q <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign trig = ((ttype & ((tpol & s & ~d_q) | (~tpol & ~s & d_q))) |
                 (~ttype & ~(s ^ tpol))) & CH_MASK;

  always_comb begin
    clr = '0;
    if (wr_en && (reg_sel == 4'h1)) begin
      clr = ~data_i;
    end
    if (complete && ttype[src]) begin
      clr[src] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      eie   <= '0;
      eip   <= '0;
      ttype <= XIRQ_TRIGGER_TYPE & CH_MASK;
      tpol  <= XIRQ_TRIGGER_POLARITY & CH_MASK;
    end else begin
      // A simultaneous set dominates a clear of the same bit
      eip <= ((eip & ~clr) | (trig & eie)) & CH_MASK;
      if (wr_en) begin
        case (reg_sel)
          4'h0:    eie   <= data_i & CH_MASK;
          4'h3:    ttype <= data_i & CH_MASK;
          4'h4:    tpol  <= data_i & CH_MASK;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < 32; i++) begin
        prio[i] <= '0;
      end
    end else if (wr_en && reg_sel[3]) begin
      for (int unsigned j = 0; j < 4; j++) begin
        if (CH_MASK[{reg_sel[2:0], j[1:0]}]) begin
          prio[{reg_sel[2:0], j[1:0]}] <= data_i[8*j +: PRIO_BITS];
        end
      end
    end
  end

  assign cand = eip & eie & elig;

  // Strict greater-than keeps the lowest channel index on equal priority
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    win_prio  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (cand[i] && (!win_found || (prio[i] > win_prio))) begin
        win_found = 1'b1;
        win_ch    = 5'(i);
        win_prio  = prio[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      src       <= '0;
      cpu_irq_o <= 1'b0;
    end else begin
      cpu_irq_o <= 1'b0;
      if (state == IDLE) begin
        if (win_found) begin
          src       <= win_ch;
          cpu_irq_o <= 1'b1;
          state     <= BUSY;
        end
      end else if (esc_wr) begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (reg_sel[3]) begin
      for (int unsigned j = 0; j < 4; j++) begin
        rdata[8*j +: PRIO_BITS] = prio[{reg_sel[2:0], j[1:0]}];
      end
    end else begin
      case (reg_sel[2:0])
        3'h0:    rdata = eie;
        3'h1:    rdata = eip;
        3'h2:    rdata = {(state == BUSY), 26'b0, src};
        3'h3:    rdata = ttype;
        3'h4:    rdata = tpol;
`ifdef CELLRV32_XIRQ_PRIO_THRESHOLD_EN
        3'h5:    rdata = 32'(thresh);
`endif
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o  <= (rden_i | wren_i) & acc_en;
      data_o <= (rden_i & acc_en) ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_cellrv32_xirq_prio.sv
// Directed self-checking bench for cellrv32_xirq_prio (default parameters).
module tb_cellrv32_xirq_prio;

  localparam logic [31:0] BASE = 32'hFFFF_FF80;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [31:0] addr_i, data_i, data_o, xirq_i;
  logic        rden_i, wren_i, ack_o, cpu_irq_o;

  int total = 0;
  int bad   = 0;
  int irq_cnt = 0;
  int cnt0;
  logic [31:0] rd;
  logic        ak;

  cellrv32_xirq_prio dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .addr_i    (addr_i),
    .rden_i    (rden_i),
    .wren_i    (wren_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .ack_o     (ack_o),
    .xirq_i    (xirq_i),
    .cpu_irq_o (cpu_irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cpu_irq_o) irq_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    addr_i = BASE + 32'(off);
    data_i = d;
    wren_i = 1'b1;
    @(negedge clk);
    wren_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic k);
    @(negedge clk);
    addr_i = a;
    rden_i = 1'b1;
    @(negedge clk);
    d = data_o;
    k = ack_o;
    rden_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    logic        k;
    bus_rd(BASE + 32'(off), v, k);
    check({tag, "_ack"}, 32'(k), 32'd1);
    check(tag, v, exp);
  endtask

  task automatic pulse(input logic [31:0] m);
    @(negedge clk);
    xirq_i = xirq_i | m;
    idle(3);
    xirq_i = xirq_i & ~m;
  endtask

  task automatic complete();
    bus_wr(8'h08, 32'h0);
  endtask

  initial begin
    rstn_i = 1'b0; addr_i = '0; data_i = '0; rden_i = 1'b0; wren_i = 1'b0; xirq_i = '0;
    idle(3);
    check("rst_cpu_irq", 32'(cpu_irq_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    rstn_i = 1'b1;
    idle(2);
    rd_chk("rst_eie",   8'h00, 32'h0);
    rd_chk("rst_eip",   8'h04, 32'h0);
    rd_chk("rst_esc",   8'h08, 32'h0);
    rd_chk("rst_ttype", 8'h0C, 32'h0);
    rd_chk("rst_tpol",  8'h10, 32'h0);
    rd_chk("rst_prio0", 8'h20, 32'h0);

    // outside the window: no ack, data 0
    bus_rd(BASE + 32'h40, rd, ak);
    check("oow_ack", 32'(ak), 32'd0);
    check("oow_data", rd, 32'h0);

    // ch3 rising edge, claim and complete
    bus_wr(8'h0C, 32'h8);
    bus_wr(8'h10, 32'h8);
    bus_wr(8'h00, 32'h8);
    cnt0 = irq_cnt;
    pulse(32'h8);
    idle(10);
    check("e3_irqs", 32'(irq_cnt - cnt0), 32'd1);
    rd_chk("e3_eip", 8'h04, 32'h8);
    rd_chk("e3_esc", 8'h08, 32'h8000_0003);
    complete();
    idle(3);
    rd_chk("e3_eip_clr", 8'h04, 32'h0);
    rd_chk("e3_esc_done", 8'h08, 32'h0000_0003);
    check("e3_irqs_after", 32'(irq_cnt - cnt0), 32'd1);

    // priority: ch1=2, ch5=6
    bus_wr(8'h00, 32'h0);
    bus_wr(8'h0C, 32'hFFFF_FFFF);
    bus_wr(8'h10, 32'hFFFF_FFFF);
    bus_wr(8'h20, 32'h0000_0200);
    bus_wr(8'h24, 32'hFFFF_FFFF);
    rd_chk("prio_mask", 8'h24, 32'h0707_0707);
    bus_wr(8'h24, 32'h0000_0600);
    bus_wr(8'h00, 32'h22);
    cnt0 = irq_cnt;
    pulse(32'h22);
    idle(10);
    check("pr_irqs1", 32'(irq_cnt - cnt0), 32'd1);
    rd_chk("pr_eip", 8'h04, 32'h22);
    rd_chk("pr_esc5", 8'h08, 32'h8000_0005);
    complete();
    idle(5);
    check("pr_irqs2", 32'(irq_cnt - cnt0), 32'd2);
    rd_chk("pr_esc1", 8'h08, 32'h8000_0001);
    complete();
    idle(5);
    rd_chk("pr_eip_clr", 8'h04, 32'h0);

    // equal priority: lowest index first
    bus_wr(8'h24, 32'h0000_0200);
    pulse(32'h22);
    idle(10);
    rd_chk("tie_esc1", 8'h08, 32'h8000_0001);
    complete();
    idle(5);
    rd_chk("tie_esc5", 8'h08, 32'h8000_0005);
    complete();
    idle(5);

    // ch0 level-high: re-pends after complete while line held
    bus_wr(8'h00, 32'h0);
    bus_wr(8'h0C, 32'h0);
    bus_wr(8'h10, 32'h1);
    @(negedge clk);
    xirq_i[0] = 1'b1;
    idle(4);
    cnt0 = irq_cnt;
    bus_wr(8'h00, 32'h1);
    idle(8);
    check("lv_irqs1", 32'(irq_cnt - cnt0), 32'd1);
    rd_chk("lv_esc", 8'h08, 32'h8000_0000);
    complete();
    idle(8);
    check("lv_irqs2", 32'(irq_cnt - cnt0), 32'd2);
    rd_chk("lv_eip", 8'h04, 32'h1);
    xirq_i[0] = 1'b0;
    idle(5);
    bus_wr(8'h04, 32'hFFFF_FFFE);
    rd_chk("lv_eip_clr", 8'h04, 32'h0);
    complete();
    idle(10);
    check("lv_irqs_end", 32'(irq_cnt - cnt0), 32'd2);
    rd_chk("lv_esc_idle", 8'h08, 32'h0);

    // edge on ch2 coincides with EIP clear of bit 2: set wins
    bus_wr(8'h00, 32'h0);
    bus_wr(8'h0C, 32'h4);
    bus_wr(8'h10, 32'h4);
    bus_wr(8'h00, 32'h4);
    cnt0 = irq_cnt;
    @(negedge clk);
    xirq_i[2] = 1'b1;
    @(negedge clk);
    bus_wr(8'h04, 32'hFFFF_FFFB);
    rd_chk("sw_eip", 8'h04, 32'h4);
    idle(6);
    check("sw_irqs", 32'(irq_cnt - cnt0), 32'd1);
    rd_chk("sw_esc", 8'h08, 32'h8000_0002);
    complete();
    idle(3);
    rd_chk("sw_eip_clr", 8'h04, 32'h0);
    xirq_i[2] = 1'b0;
    idle(4);

    // reset while BUSY
    bus_wr(8'h20, 32'h0505_0505);
    pulse(32'h4);
    idle(8);
    rd_chk("rb_busy", 8'h08, 32'h8000_0002);
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    check("rb_cpu_irq", 32'(cpu_irq_o), 32'd0);
    idle(2);
    rstn_i = 1'b1;
    cnt0 = irq_cnt;
    rd_chk("rb_eie",   8'h00, 32'h0);
    rd_chk("rb_eip",   8'h04, 32'h0);
    rd_chk("rb_esc",   8'h08, 32'h0);
    rd_chk("rb_ttype", 8'h0C, 32'h0);
    rd_chk("rb_tpol",  8'h10, 32'h0);
    rd_chk("rb_prio0", 8'h20, 32'h0);
    idle(10);
    check("rb_irqs", 32'(irq_cnt - cnt0), 32'd0);

`ifdef CELLRV32_XIRQ_PRIO_THRESHOLD_EN
    bus_wr(8'h0C, 32'h80);
    bus_wr(8'h10, 32'h80);
    bus_wr(8'h24, 32'h0300_0000);
    bus_wr(8'h14, 32'h4);
    rd_chk("th_reg", 8'h14, 32'h4);
    bus_wr(8'h00, 32'h80);
    cnt0 = irq_cnt;
    pulse(32'h80);
    idle(10);
    check("th_masked", 32'(irq_cnt - cnt0), 32'd0);
    rd_chk("th_eip", 8'h04, 32'h80);
    bus_wr(8'h14, 32'h3);
    idle(8);
    check("th_irqs", 32'(irq_cnt - cnt0), 32'd1);
    rd_chk("th_esc", 8'h08, 32'h8000_0007);
    complete();
    idle(3);
    rd_chk("th_eip_clr", 8'h04, 32'h0);
`else
    bus_wr(8'h14, 32'h5);
    rd_chk("th_absent", 8'h14, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
